axis_fifo: RTL and testbench

- Synchronous single-clock FIFO with AXI4-Stream-style valid/ready ports on both sides.
- The write side is a stream slave and the read side is a stream master.
- It is used as the generic elastic buffer between stream producers and consumers in the core.
- It also exposes full and empty status flags for observation and debug.

---
 rtl/axis_fifo_if.sv | 12 +
 rtl/axis_fifo.sv | 65 ++++++
 tb/tb_axis_fifo.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/axis_fifo_if.sv
// Valid/ready stream bundle shared by both FIFO ports.
// master drives data and valid; slave drives ready.
interface axis_fifo_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_fifo.sv
// Single-clock stream FIFO, 2**ADDR_WIDTH entries, registered read data (word appears after the handshake edge).
// Backpressure: write_tready = !full, read_tvalid = !empty; no fall-through.
module axis_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic         clk,
   input  logic         resetn,
   axis_fifo_if.slave   write_s,
   axis_fifo_if.master  read_m,
   output logic         full,
   output logic         empty
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  wr_en, rd_en;

   // Extra pointer MSB separates a full lap from an empty FIFO.
   assign empty = (rd_ptr_q == wr_ptr_q);
   assign full  = (rd_ptr_q[ADDR_WIDTH-1:0] == wr_ptr_q[ADDR_WIDTH-1:0]) &&
                  (rd_ptr_q[ADDR_WIDTH] != wr_ptr_q[ADDR_WIDTH]);

   assign write_s.tready = !full;
   assign read_m.tvalid  = !empty;
   assign read_m.tdata   = rdata_q;

   assign wr_en = write_s.tvalid && !full;
   assign rd_en = read_m.tready && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      rdata_d  = rdata_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         rdata_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rdata_q  <= rdata_d;
      end
   end

   // Storage is deliberately left unreset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= write_s.tdata;
      end
   end
endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo against a queue-based FIFO model.
module tb_axis_fifo;
   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic full, empty;

   axis_fifo_if #(.DATA_WIDTH(DW)) wr_if ();
   axis_fifo_if #(.DATA_WIDTH(DW)) rd_if ();

   axis_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .write_s (wr_if.slave),
      .read_m  (rd_if.master),
      .full    (full),
      .empty   (empty)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] model_q[$];
   logic [DW-1:0] model_rdata = '0;
   bit            last_wr, last_rd;

   // Drive one cycle of inputs, advance past the edge, and update the model.
   task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rr);
      wr_if.tvalid = wv;
      wr_if.tdata  = wd;
      rd_if.tready = rr;
      last_wr = wv && (model_q.size() < DEPTH);
      last_rd = rr && (model_q.size() > 0);
      @(posedge clk);
      #1;
      if (last_rd) model_rdata = model_q.pop_front();
      if (last_wr) model_q.push_back(wd);
      wr_if.tvalid = 1'b0;
      rd_if.tready = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      @(posedge clk);
      #1;
      model_q.delete();
      model_rdata = '0;
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      wr_if.tvalid = 1'b1;
      wr_if.tdata  = 8'hA5;
      rd_if.tready = 1'b1;
      do_reset();
      wr_if.tvalid = 1'b0;
      rd_if.tready = 1'b0;
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
      n_checks++; if (wr_if.tready !== 1'b1) begin n_fail++; $display("FAIL reset_wready got %b want 1", wr_if.tready); end
      n_checks++; if (rd_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", rd_if.tvalid); end
      n_checks++; if (rd_if.tdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", rd_if.tdata); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, DW'($urandom), 1'b0);
         n_checks++;
         if (full !== (model_q.size() == DEPTH)) begin
            n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, full, model_q.size() == DEPTH);
         end
      end
      n_checks++; if (wr_if.tready !== 1'b0) begin n_fail++; $display("FAIL fill_wready got %b want 0", wr_if.tready); end
      cycle(1'b1, 8'hEE, 1'b0);
      n_checks++; if (full !== 1'b1 || model_q.size() != DEPTH) begin n_fail++; $display("FAIL fill_overflow full=%b size=%0d want 1/32", full, model_q.size()); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, '0, 1'b1);
         n_checks++;
         if (rd_if.tdata !== model_rdata) begin
            n_fail++; $display("FAIL drain_data[%0d] got %h want %h", i, rd_if.tdata, model_rdata);
         end
      end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", empty); end
      cycle(1'b0, '0, 1'b1);
      n_checks++; if (rd_if.tdata !== model_rdata) begin n_fail++; $display("FAIL drain_hold got %h want %h", rd_if.tdata, model_rdata); end
   endtask

   task automatic test_concurrent();
      logic [DW-1:0] stim [DEPTH];
      logic [DW-1:0] resp [$];
      int widx = 0;
      int cyc  = 0;
      do_reset();
      for (int i = 0; i < DEPTH; i++) stim[i] = DW'($urandom);
      while ((widx < DEPTH || resp.size() < DEPTH) && cyc < 2000) begin
         bit wv, rr;
         wv = (widx < DEPTH) && ($urandom_range(0, 2) != 0);
         rr = $urandom_range(0, 1) == 1;
         cycle(wv, (widx < DEPTH) ? stim[widx] : '0, rr);
         if (last_wr) widx++;
         if (last_rd) begin
            resp.push_back(rd_if.tdata);
            n_checks++;
            if (rd_if.tdata !== model_rdata) begin
               n_fail++; $display("FAIL stream_data got %h want %h", rd_if.tdata, model_rdata);
            end
         end
         cyc++;
      end
      n_checks++;
      if (resp.size() != DEPTH) begin
         n_fail++; $display("FAIL stream_timeout got %0d words want %0d", resp.size(), DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (resp[i] !== stim[i]) begin n_fail++; $display("FAIL stream_order[%0d] got %h want %h", i, resp[i], stim[i]); end
         end
      end
   endtask

   task automatic test_full_boundary();
      logic [DW-1:0] first;
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0);
      first = model_q[0];
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fb_full got %b want 1", full); end
      cycle(1'b1, 8'h5A, 1'b1);
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fb_read_only_full got %b want 0", full); end
      n_checks++; if (rd_if.tdata !== first) begin n_fail++; $display("FAIL fb_head got %h want %h", rd_if.tdata, first); end
      cycle(1'b1, 8'h5A, 1'b0);
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fb_refull got %b want 1", full); end
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, '0, 1'b1);
         n_checks++;
         if (rd_if.tdata !== model_rdata) begin n_fail++; $display("FAIL fb_drain[%0d] got %h want %h", i, rd_if.tdata, model_rdata); end
      end
      n_checks++; if (rd_if.tdata !== 8'h5A || empty !== 1'b1) begin n_fail++; $display("FAIL fb_last got %h/%b want 5a/1", rd_if.tdata, empty); end
   endtask

   task automatic test_wraparound();
      do_reset();
      for (int i = 0; i < 20; i++) cycle(1'b1, DW'(8'h80 + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, '0, 1'b1);
         n_checks++;
         if (rd_if.tdata !== DW'(8'h80 + i)) begin n_fail++; $display("FAIL wrap_pre[%0d] got %h want %h", i, rd_if.tdata, 8'h80 + i); end
      end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty1 got %b want 1", empty); end
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0);
      n_checks++; if (full !== 1'b1 || empty !== 1'b0) begin n_fail++; $display("FAIL wrap_full got %b/%b want 1/0", full, empty); end
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, '0, 1'b1);
         n_checks++;
         if (rd_if.tdata !== DW'(i)) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", i, rd_if.tdata, i); end
      end
      n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL wrap_empty2 got %b/%b want 1/0", empty, full); end
   endtask

   task automatic test_midreset();
      for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      n_checks++; if (empty !== 1'b1 || rd_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_async got %b/%b want 1/0", empty, rd_if.tvalid); end
      @(posedge clk);
      #1;
      model_q.delete();
      model_rdata = '0;
      resetn = 1'b1;
      cycle(1'b1, 8'h3C, 1'b0);
      cycle(1'b0, '0, 1'b1);
      n_checks++; if (rd_if.tdata !== 8'h3C || empty !== 1'b1) begin n_fail++; $display("FAIL midreset_after got %h/%b want 3c/1", rd_if.tdata, empty); end
   endtask

   initial begin
      wr_if.tvalid = 1'b0;
      wr_if.tdata  = '0;
      rd_if.tready = 1'b0;
      test_reset();
      test_fill();
      test_drain();
      test_concurrent();
      test_full_boundary();
      test_wraparound();
      test_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
